pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Program-counter register and instruction-fetch sequencer of MonoCPU; the consumer of the next-PC select.
//  Produces the sequential address (PC+4, the "Asum" operand), accepts a branch redirect (select + ALU target),
//  issues one instruction-memory request at a time with valid/ready, and hands fetched words to decode.
// PARAMETERS
//  XLEN      32            address/instruction width
//  RESET_PC  32'h0000_0000 PC loaded by reset
//  INC       4             sequential PC increment in bytes
// PORTS
//  clk              in   1     clock, all state updates on rising edge
//  rst_n            in   1     reset, asynchronous assert, active low
//  branch_taken_i   in   1     redirect strobe (next-PC select = target), single-cycle
//  branch_target_i  in   XLEN  redirect address (ALU result)
//  pc_plus4_o       out  XLEN  pc + INC, combinational from PC register
//  imem_req_valid_o out  1     fetch request valid
//  imem_req_ready_i in   1     memory accepts request
//  imem_req_addr_o  out  XLEN  fetch address (= PC register)
//  imem_rsp_valid_i in   1     read data valid
//  imem_rsp_data_i  in   XLEN  read data
//  instr_valid_o    out  1     instruction presented to decode
//  instr_ready_i    in   1     decode accepts instruction
//  instr_o          out  XLEN  fetched instruction
//  instr_pc_o       out  XLEN  address of instr_o
//  misalign_o       out  1     one-cycle pulse: misaligned redirect rejected (0 when macro off)
// BEHAVIOUR
//  - Reset (async, rst_n=0): pc=RESET_PC, state=S_IDLE, kill=0; imem_req_valid_o=0, instr_valid_o=0,
//    instr_o=0, instr_pc_o=0, misalign_o=0; pc_plus4_o=RESET_PC+INC. Reset mid-fetch abandons everything.
//  - FSM: S_IDLE -> S_REQ on first edge after release (unconditional).
//    S_REQ: req_valid=1, addr=pc; req_ready=1 -> S_WAIT. S_WAIT: rsp_valid=1 -> S_OUT if kill=0, else drop
//    data, clear kill, -> S_REQ. S_OUT: instr_valid=1, instr/instr_pc registered at rsp;
//    instr_valid&instr_ready -> pc<=pc+INC, -> S_REQ.
//  - One outstanding request; rsp_valid outside S_WAIT ignored. Best case 3 cycles/instruction.
//  - instr_o/instr_pc_o stable while instr_valid_o=1 and instr_ready_i=0; no request issued in S_OUT.
//  - Redirect (branch_taken_i=1), any state except S_IDLE: pc<=target next edge.
//    S_REQ, req_ready=0: request withdrawn, next-cycle addr=target. S_REQ, req_ready=1: old-pc request
//    accepted, -> S_WAIT with kill=1. S_WAIT (even with rsp_valid same cycle): kill=1 (response dropped);
//    a simultaneous rsp counts as the killed one -> S_REQ.
//    S_OUT: instr_valid_o drops next cycle, -> S_REQ; same-cycle instr handshake still counts as consumed.
//    Redirect wins over pc+INC; repeated redirect while kill=1 updates pc, kill stays 1.
//  - Redirect in S_IDLE ignored.
//  - Arithmetic mod 2^XLEN: pc=FFFF_FFFC -> pc_plus4_o=0, next fetch 0.
// CONFIGURATION
//  PC_FETCH_MISALIGN_CHECK_EN defined: target[1:0]!=0 -> redirect ignored (pc, state, kill unchanged),
//    misalign_o=1 for one cycle.
//  Undefined: target[1:0] forced to 2'b00, redirect always taken; misalign_o tied 0.
// STRUCTURE
//  Package pc_fetch_pkg: XLEN, INC, fetch_state_e {S_IDLE,S_REQ,S_WAIT,S_OUT}.
//  Sub-module fetch_out_reg: instr/instr_pc holding register with load/flush; FSM and PC stay in top.
// TESTING
//  1 rst_n=0, RESET_PC=0 -> req_valid=0, pc_plus4_o=4; release -> req_valid=1, addr=0 next cycle.
//  2 ready=1, 1-cycle mem, instr_ready=1 -> instr_pc_o 0,4,8 with mem words; one instruction/3 cycles.
//  3 instr_ready=0 five cycles in S_OUT -> instr_o stable, req_valid=0 throughout, pc unchanged.
//  4 redirect 0x100 in S_WAIT for addr 0x8 -> rsp dropped, instr_valid_o stays 0, next req addr 0x100.
//  5 RESET_PC=FFFF_FFFC -> first instr_pc FFFF_FFFC, pc_plus4_o=0, second fetch addr 0.
//  6 redirect 0x102: macro on -> misalign_o pulse, sequential addr kept; off -> next addr 0x100.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg
//   Shared definitions for the MonoCPU fetch unit.
//   XLEN : address / instruction width
//   INC  : sequential PC increment in bytes
//   fetch_state_e : fetch sequencer states
package pc_fetch_pkg;

    localparam int XLEN = 32;
    localparam int INC  = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_out_reg.sv
// fetch_out_reg
//   Holding register for the instruction handed to decode and its address.
//   Ports:
//     clk, rst_n        clock, async active-low reset (clears both words)
//     load              capture instr_d / pc_d
//     flush             clear both words (takes priority over load)
//     instr_d, pc_d     fetched word and the address it came from
//     instr_q, pc_q     registered copies presented to decode
module fetch_out_reg
    import pc_fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            flush,
    input  logic [XLEN-1:0] instr_d,
    input  logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] instr_q,
    output logic [XLEN-1:0] pc_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= '0;
            pc_q    <= '0;
        end else if (flush) begin
            instr_q <= '0;
            pc_q    <= '0;
        end else if (load) begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Program counter and instruction-fetch sequencer. Issues one instruction
//   memory request at a time, accepts branch redirects and hands fetched
//   words to decode with valid/ready.
//   Optional feature macro: PC_FETCH_MISALIGN_CHECK_EN
//     defined   : redirects to a non word-aligned target are ignored and
//                 misalign_o pulses for one cycle
//     undefined : target[1:0] is forced to 0, misalign_o stays 0
//   Ports:
//     clk, rst_n                        clock, async active-low reset
//     branch_taken_i, branch_target_i   redirect strobe and target address
//     pc_plus4_o                        pc + INC (sequential address)
//     imem_req_valid_o/_ready_i/_addr_o instruction memory request
//     imem_rsp_valid_i/_data_i          instruction memory response
//     instr_valid_o/_ready_i            handshake towards decode
//     instr_o, instr_pc_o               fetched word and its address
//     misalign_o                        rejected misaligned redirect pulse
//
//   state  | meaning
//   S_IDLE | first cycle after reset, no request yet
//   S_REQ  | request for pc presented to memory
//   S_WAIT | request accepted, waiting for the response
//   S_OUT  | fetched word presented to decode
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [XLEN-1:0] imem_rsp_data_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            misalign_o
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            kill_q, kill_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] target;
    logic            redirect;
    logic            out_load, out_flush;

`ifdef PC_FETCH_MISALIGN_CHECK_EN
    assign target     = branch_target_i;
    assign redirect   = branch_taken_i && (state_q != S_IDLE) &&
                        (branch_target_i[1:0] == 2'b00);
    assign misalign_d = branch_taken_i && (state_q != S_IDLE) &&
                        (branch_target_i[1:0] != 2'b00);
`else
    assign target     = {branch_target_i[XLEN-1:2], 2'b00};
    assign redirect   = branch_taken_i && (state_q != S_IDLE);
    assign misalign_d = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        kill_d    = kill_q;
        out_load  = 1'b0;
        out_flush = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                // A redirect in the acceptance cycle still lets the old-pc
                // request go out; its response must then be discarded.
                if (imem_req_ready_i) begin
                    state_d = S_WAIT;
                    kill_d  = redirect;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid_i) begin
                    if (kill_q || redirect) begin
                        state_d = S_REQ;
                        kill_d  = 1'b0;
                    end else begin
                        state_d  = S_OUT;
                        out_load = 1'b1;
                    end
                end else if (redirect) begin
                    kill_d = 1'b1;
                end
            end
            S_OUT: begin
                if (redirect) begin
                    state_d   = S_REQ;
                    out_flush = 1'b1;
                end else if (instr_ready_i) begin
                    state_d = S_REQ;
                    pc_d    = pc_q + XLEN'(INC);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (redirect) begin
            pc_d = target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            kill_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            kill_q     <= kill_d;
            misalign_q <= misalign_d;
        end
    end

    fetch_out_reg u_out_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (out_load),
        .flush   (out_flush),
        .instr_d (imem_rsp_data_i),
        .pc_d    (pc_q),
        .instr_q (instr_o),
        .pc_q    (instr_pc_o)
    );

    assign pc_plus4_o       = pc_q + XLEN'(INC);
    assign imem_req_valid_o = (state_q == S_REQ);
    assign imem_req_addr_o  = pc_q;
    assign instr_valid_o    = (state_q == S_OUT);
    assign misalign_o       = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit
//   Directed scenarios followed by a randomized run against a transaction
//   level reference: the stream of instructions delivered to decode must be
//   consecutive words from the last redirect target, each carrying the
//   memory word for its own address.
module tb_pc_fetch_unit;
    import pc_fetch_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, branch_taken, req_ready, rsp_valid, instr_ready;
    logic [31:0] branch_target, rsp_data;
    logic [31:0] pc_plus4, req_addr, instr, instr_pc;
    logic        req_valid, instr_valid, misalign;

    logic        w_rst_n, w_req_ready, w_rsp_valid, w_instr_ready;
    logic [31:0] w_rsp_data;
    logic [31:0] w_pc_plus4, w_req_addr, w_instr, w_instr_pc;
    logic        w_req_valid, w_instr_valid, w_misalign;

    int checks = 0;
    int errors = 0;

    pc_fetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .branch_taken_i(branch_taken), .branch_target_i(branch_target),
        .pc_plus4_o(pc_plus4),
        .imem_req_valid_o(req_valid), .imem_req_ready_i(req_ready),
        .imem_req_addr_o(req_addr),
        .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data),
        .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
        .instr_o(instr), .instr_pc_o(instr_pc), .misalign_o(misalign)
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst_n(w_rst_n),
        .branch_taken_i(1'b0), .branch_target_i(32'h0),
        .pc_plus4_o(w_pc_plus4),
        .imem_req_valid_o(w_req_valid), .imem_req_ready_i(w_req_ready),
        .imem_req_addr_o(w_req_addr),
        .imem_rsp_valid_i(w_rsp_valid), .imem_rsp_data_i(w_rsp_data),
        .instr_valid_o(w_instr_valid), .instr_ready_i(w_instr_ready),
        .instr_o(w_instr), .instr_pc_o(w_instr_pc), .misalign_o(w_misalign)
    );

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; branch_taken = 1'b0; branch_target = '0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; instr_ready = 1'b0;
        tick(); tick();
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", req_valid); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b expected 0", instr_valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", instr); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h expected 0", instr_pc); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b expected 0", misalign); end
        checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pc_plus4: got %h expected 4", pc_plus4); end
        // redirect during the idle cycle must be ignored
        branch_taken = 1'b1; branch_target = 32'h80;
        rst_n = 1'b1;
        tick();
        branch_taken = 1'b0;
        checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid: got %b expected 1", req_valid); end
        checks++; if (req_addr !== 32'h0) begin errors++; $display("FAIL first_req_addr: got %h expected 0", req_addr); end
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 3; k++) begin
            checks++; if (req_valid !== 1'b1 || req_addr !== 32'(4*k)) begin errors++; $display("FAIL seq_req: got v=%b a=%h expected v=1 a=%h", req_valid, req_addr, 32'(4*k)); end
            req_ready = 1'b1; tick(); req_ready = 1'b0;
            checks++; if (req_valid !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL seq_wait: got req=%b iv=%b expected 0 0", req_valid, instr_valid); end
            rsp_valid = 1'b1; rsp_data = memfn(32'(4*k)); tick(); rsp_valid = 1'b0;
            checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'(4*k) || instr !== memfn(32'(4*k))) begin errors++; $display("FAIL seq_out: got v=%b pc=%h i=%h expected v=1 pc=%h i=%h", instr_valid, instr_pc, instr, 32'(4*k), memfn(32'(4*k))); end
            instr_ready = 1'b1; tick(); instr_ready = 1'b0;
        end
    endtask

    task automatic test_stall();
        req_ready = 1'b1; tick(); req_ready = 1'b0;
        rsp_valid = 1'b1; rsp_data = memfn(32'hC); tick(); rsp_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++; if (instr_valid !== 1'b1 || instr !== memfn(32'hC) || instr_pc !== 32'hC) begin errors++; $display("FAIL stall_hold: got v=%b i=%h pc=%h expected v=1 i=%h pc=c", instr_valid, instr, instr_pc, memfn(32'hC)); end
            checks++; if (req_valid !== 1'b0 || pc_plus4 !== 32'h10) begin errors++; $display("FAIL stall_noreq: got req=%b pc4=%h expected 0 10", req_valid, pc_plus4); end
            tick();
        end
        instr_ready = 1'b1; tick(); instr_ready = 1'b0;
        checks++; if (req_valid !== 1'b1 || req_addr !== 32'h10) begin errors++; $display("FAIL stall_next: got v=%b a=%h expected 1 10", req_valid, req_addr); end
    endtask

    task automatic test_redirect_wait();
        branch_taken = 1'b1; branch_target = 32'h8; tick(); branch_taken = 1'b0;
        checks++; if (req_valid !== 1'b1 || req_addr !== 32'h8) begin errors++; $display("FAIL redir_req_withdraw: got v=%b a=%h expected 1 8", req_valid, req_addr); end
        req_ready = 1'b1; tick(); req_ready = 1'b0;
        branch_taken = 1'b1; branch_target = 32'h100;
        rsp_valid = 1'b1; rsp_data = memfn(32'h8); tick();
        branch_taken = 1'b0; rsp_valid = 1'b0;
        checks++; if (instr_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h100) begin errors++; $display("FAIL redir_wait_same: got iv=%b rv=%b a=%h expected 0 1 100", instr_valid, req_valid, req_addr); end
        req_ready = 1'b1; tick(); req_ready = 1'b0;
        branch_taken = 1'b1; branch_target = 32'h200; tick();
        branch_target = 32'h300; tick(); branch_taken = 1'b0;
        checks++; if (req_valid !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL redir_wait_hold: got rv=%b iv=%b expected 0 0", req_valid, instr_valid); end
        rsp_valid = 1'b1; rsp_data = memfn(32'h100); tick(); rsp_valid = 1'b0;
        checks++; if (instr_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h300) begin errors++; $display("FAIL redir_wait_kill: got iv=%b rv=%b a=%h expected 0 1 300", instr_valid, req_valid, req_addr); end
    endtask

    task automatic test_redirect_out();
        req_ready = 1'b1; tick(); req_ready = 1'b0;
        rsp_valid = 1'b1; rsp_data = memfn(32'h300); tick(); rsp_valid = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h300 || instr !== memfn(32'h300)) begin errors++; $display("FAIL redir_out_pre: got v=%b pc=%h i=%h expected 1 300 %h", instr_valid, instr_pc, instr, memfn(32'h300)); end
        instr_ready = 1'b1; branch_taken = 1'b1; branch_target = 32'h40; tick();
        instr_ready = 1'b0; branch_taken = 1'b0;
        checks++; if (instr_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h40) begin errors++; $display("FAIL redir_out: got iv=%b rv=%b a=%h expected 0 1 40", instr_valid, req_valid, req_addr); end
    endtask

    task automatic test_misalign();
        branch_taken = 1'b1; branch_target = 32'h102; tick(); branch_taken = 1'b0;
`ifdef PC_FETCH_MISALIGN_CHECK_EN
        checks++; if (misalign !== 1'b1 || req_addr !== 32'h40) begin errors++; $display("FAIL misalign_pulse: got m=%b a=%h expected 1 40", misalign, req_addr); end
        tick();
        checks++; if (misalign !== 1'b0 || req_addr !== 32'h40) begin errors++; $display("FAIL misalign_end: got m=%b a=%h expected 0 40", misalign, req_addr); end
`else
        checks++; if (misalign !== 1'b0 || req_addr !== 32'h100) begin errors++; $display("FAIL misalign_force: got m=%b a=%h expected 0 100", misalign, req_addr); end
`endif
    endtask

    task automatic test_wrap();
        checks++; if (w_pc_plus4 !== 32'h0 || w_req_valid !== 1'b0) begin errors++; $display("FAIL wrap_reset: got pc4=%h rv=%b expected 0 0", w_pc_plus4, w_req_valid); end
        w_rst_n = 1'b1; tick();
        checks++; if (w_req_valid !== 1'b1 || w_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req0: got v=%b a=%h expected 1 fffffffc", w_req_valid, w_req_addr); end
        w_req_ready = 1'b1; tick(); w_req_ready = 1'b0;
        w_rsp_valid = 1'b1; w_rsp_data = memfn(32'hFFFF_FFFC); tick(); w_rsp_valid = 1'b0;
        checks++; if (w_instr_valid !== 1'b1 || w_instr_pc !== 32'hFFFF_FFFC || w_instr !== memfn(32'hFFFF_FFFC) || w_pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_out: got v=%b pc=%h i=%h pc4=%h", w_instr_valid, w_instr_pc, w_instr, w_pc_plus4); end
        w_instr_ready = 1'b1; tick(); w_instr_ready = 1'b0;
        checks++; if (w_req_valid !== 1'b1 || w_req_addr !== 32'h0 || w_misalign !== 1'b0) begin errors++; $display("FAIL wrap_req1: got v=%b a=%h m=%b expected 1 0 0", w_req_valid, w_req_addr, w_misalign); end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, paddr, tgt, sv_instr, sv_pc;
        logic        pend, prev_stall, exp_mis, br, eff;
        int          lat, delivered, r;
        // reset in the middle of an outstanding fetch
        req_ready = 1'b1; tick(); req_ready = 1'b0;
        rst_n = 1'b0; #1;
        checks++; if (req_valid !== 1'b0 || instr_valid !== 1'b0 || instr_pc !== 32'h0) begin errors++; $display("FAIL reset_midfetch: got rv=%b iv=%b pc=%h expected 0 0 0", req_valid, instr_valid, instr_pc); end
        tick(); rst_n = 1'b1; tick();
        exp_pc = 32'h0; pend = 1'b0; lat = 0; paddr = '0; prev_stall = 1'b0;
        sv_instr = '0; sv_pc = '0; exp_mis = 1'b0; delivered = 0;
        for (int c = 0; c < 3000; c++) begin
            if (req_valid === 1'b1) begin
                checks++; if (req_addr !== exp_pc || pc_plus4 !== exp_pc + 32'd4) begin errors++; $display("FAIL rnd_req_addr: got a=%h pc4=%h expected a=%h cycle %0d", req_addr, pc_plus4, exp_pc, c); end
            end
            checks++; if ((req_valid & instr_valid) !== 1'b0) begin errors++; $display("FAIL rnd_exclusive: got rv=%b iv=%b expected not both", req_valid, instr_valid); end
            if (prev_stall) begin
                checks++; if (instr_valid !== 1'b1 || instr !== sv_instr || instr_pc !== sv_pc) begin errors++; $display("FAIL rnd_stall_hold: got v=%b i=%h pc=%h expected 1 %h %h", instr_valid, instr, instr_pc, sv_instr, sv_pc); end
            end
            checks++; if (misalign !== exp_mis) begin errors++; $display("FAIL rnd_misalign: got %b expected %b cycle %0d", misalign, exp_mis, c); end

            if (pend) begin
                if (lat == 0) begin
                    rsp_valid = 1'b1; rsp_data = memfn(paddr); pend = 1'b0;
                end else begin
                    rsp_valid = 1'b0; lat--;
                end
            end else begin
                rsp_valid = ($urandom_range(5) == 0);
                rsp_data  = $urandom;
            end
            req_ready   = ($urandom_range(2) != 0);
            instr_ready = ($urandom_range(2) != 0);
            br          = ($urandom_range(9) == 0);
            r           = int'($urandom_range(7));
            if (r == 0)      tgt = 32'hFFFF_FFFC;
            else if (r == 1) tgt = (32'($urandom_range(1023)) << 2) | 32'($urandom_range(3));
            else             tgt = 32'($urandom_range(1023)) << 2;

            if (req_valid === 1'b1 && req_ready) begin
                pend = 1'b1; paddr = req_addr; lat = int'($urandom_range(3));
            end
            if (instr_valid === 1'b1 && instr_ready) begin
                checks++; if (instr_pc !== exp_pc || instr !== memfn(exp_pc)) begin errors++; $display("FAIL rnd_deliver: got pc=%h i=%h expected pc=%h i=%h", instr_pc, instr, exp_pc, memfn(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            exp_mis = 1'b0;
            eff = br;
`ifdef PC_FETCH_MISALIGN_CHECK_EN
            if (br && tgt[1:0] != 2'b00) begin
                eff = 1'b0; exp_mis = 1'b1;
            end
`endif
            if (eff) exp_pc = {tgt[31:2], 2'b00};
            prev_stall = (instr_valid === 1'b1) && !instr_ready && !eff;
            sv_instr = instr; sv_pc = instr_pc;
            branch_taken = br; branch_target = tgt;
            tick();
        end
        branch_taken = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; instr_ready = 1'b0;
        checks++; if (delivered < 100) begin errors++; $display("FAIL rnd_progress: got %0d instructions expected at least 100", delivered); end
    endtask

    initial begin
        w_rst_n = 1'b0; w_req_ready = 1'b0; w_rsp_valid = 1'b0;
        w_rsp_data = '0; w_instr_ready = 1'b0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_out();
        test_misalign();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

endmodule
